// File: rtl/tree_pkg.sv
// Shared node-word layout, FSM states and the ordered-key mapping used to compare doubles.
package tree_pkg;

  localparam int NODE_ID_LSB = 96;
  localparam int NODE_ID_W   = 12;
  localparam int FIDX_LSB    = 92;
  localparam int FIDX_W      = 4;
  localparam int THR_LSB     = 28;
  localparam int THR_W       = 64;
  localparam int LEFT_LSB    = 16;
  localparam int RIGHT_LSB   = 4;
  localparam int CHILD_W     = 12;
  localparam int CLASS_BIT   = 0;

  localparam logic [FIDX_W-1:0] LEAF_TAG  = 4'h3;
  localparam int                ROOT_ADDR = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL
  } state_t;

  // Monotonic map from IEEE double to unsigned key; -0 sorts below +0.
  function automatic logic [63:0] fp_key(input logic [63:0] v);
    return v[63] ? ~v : {1'b1, v[62:0]};
  endfunction

endpackage

// File: rtl/tree_fp_le.sv
// Combinational ordered a <= b on 64-bit doubles; zero latency, no flow control.
module tree_fp_le
  import tree_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        le
);

  assign le = (fp_key(a) <= fp_key(b));

endmodule

// File: rtl/tree_walker.sv
// Decision-tree walker driving a synchronous node ROM; 2 cycles per visited node, start ignored while busy.
// Define TREE_WALKER_IDCHECK_EN to abort on node_id != rom_addr.
module tree_walker
  import tree_pkg::*;
#(
  parameter int NODE_WIDTH   = 120,
  parameter int ADDR_WIDTH   = 10,
  parameter int ROM_DEPTH    = 512,
  parameter int NUM_FEATURES = 16,
  parameter int MAX_DEPTH    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_FEATURES*64-1:0] features,
  output logic                       busy,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  input  logic [NODE_WIDTH-1:0]      rom_data,
  output logic                       valid,
  output logic                       class_out,
  output logic                       error
);

  localparam int DW     = $clog2(MAX_DEPTH + 1);
  localparam int FSEL_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

  state_t                     state, state_d;
  logic [NUM_FEATURES*64-1:0] features_q;
  logic [DW-1:0]              depth, depth_d;
  logic [ADDR_WIDTH-1:0]      addr_d;
  logic                       busy_d, valid_d, class_d, error_d, latch;

  logic [63:0]        feat_arr [NUM_FEATURES];
  logic [FIDX_W-1:0]  fidx;
  logic [FSEL_W-1:0]  fsel;
  logic [63:0]        feat, thr;
  logic [CHILD_W-1:0] child;
  logic               le, is_leaf, bad_addr, depth_ovf, id_bad;
  logic               unused_bits;

  for (genvar i = 0; i < NUM_FEATURES; i++) begin : g_feat
    assign feat_arr[i] = features_q[64*i +: 64];
  end

  assign fidx      = rom_data[FIDX_LSB +: FIDX_W];
  assign fsel      = FSEL_W'(32'(fidx) % NUM_FEATURES);
  assign feat      = feat_arr[fsel];
  assign thr       = rom_data[THR_LSB +: THR_W];
  assign is_leaf   = (fidx == LEAF_TAG);
  assign child     = le ? rom_data[LEFT_LSB +: CHILD_W] : rom_data[RIGHT_LSB +: CHILD_W];
  assign bad_addr  = (32'(child) >= ROM_DEPTH);
  assign depth_ovf = (32'(depth) >= MAX_DEPTH);

`ifdef TREE_WALKER_IDCHECK_EN
  assign id_bad      = (rom_data[NODE_ID_LSB +: NODE_ID_W] != NODE_ID_W'(rom_addr));
  assign unused_bits = ^{rom_data[NODE_WIDTH-1:NODE_ID_LSB+NODE_ID_W], rom_data[RIGHT_LSB-1:CLASS_BIT+1]};
`else
  assign id_bad      = 1'b0;
  assign unused_bits = ^{rom_data[NODE_WIDTH-1:NODE_ID_LSB], rom_data[RIGHT_LSB-1:CLASS_BIT+1]};
`endif

  tree_fp_le u_le (
    .a  (feat),
    .b  (thr),
    .le (le)
  );

  always_comb begin
    state_d = state;
    addr_d  = rom_addr;
    depth_d = depth;
    busy_d  = busy;
    valid_d = 1'b0;
    class_d = class_out;
    error_d = error;
    latch   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          latch   = 1'b1;
          addr_d  = ADDR_WIDTH'(ROOT_ADDR);
          depth_d = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_EVAL;
      S_EVAL: begin
        if (id_bad || (!is_leaf && (bad_addr || depth_ovf))) begin
          valid_d = 1'b1;
          error_d = 1'b1;
          class_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (is_leaf) begin
          valid_d = 1'b1;
          error_d = 1'b0;
          class_d = rom_data[CLASS_BIT];
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          addr_d  = ADDR_WIDTH'(child);
          depth_d = depth + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rom_addr   <= '0;
      depth      <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      class_out  <= 1'b0;
      error      <= 1'b0;
      features_q <= '0;
    end else begin
      state     <= state_d;
      rom_addr  <= addr_d;
      depth     <= depth_d;
      busy      <= busy_d;
      valid     <= valid_d;
      class_out <= class_d;
      error     <= error_d;
      if (latch) features_q <= features;
    end
  end

endmodule

// File: tb/tb_tree_walker.sv
// Randomized and directed bench for tree_walker against a path-following reference model.
module tb_tree_walker;

  localparam int NW = 120;
  localparam int AW = 10;
  localparam int RD = 512;
  localparam int NF = 16;
  localparam int MD = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [NF*64-1:0] features;
  logic           busy;
  logic [AW-1:0]  rom_addr;
  logic [NW-1:0]  rom_data;
  logic           valid;
  logic           class_out;
  logic           error;

  logic [63:0] fa, fb;
  logic        fle_out;

  logic [NW-1:0] rom_mem [0:1023];
  logic [63:0]   feat_v [NF];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  tree_walker #(
    .NODE_WIDTH(NW), .ADDR_WIDTH(AW), .ROM_DEPTH(RD), .NUM_FEATURES(NF), .MAX_DEPTH(MD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .features(features), .busy(busy),
    .rom_addr(rom_addr), .rom_data(rom_data), .valid(valid), .class_out(class_out), .error(error)
  );

  tree_fp_le u_le (.a(fa), .b(fb), .le(fle_out));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ordering: real-valued compare, with -0 strictly below +0.
  function automatic bit fle(input logic [63:0] a, input logic [63:0] b);
    if (a[62:0] == 63'd0 && b[62:0] == 63'd0) return !(a[63] == 1'b0 && b[63] == 1'b1);
    return $bitstoreal(a) <= $bitstoreal(b);
  endfunction

  function automatic logic [63:0] rnd_dbl();
    logic [63:0] x;
    case ($urandom % 4)
      0, 1: x = $realtobits((real'($urandom_range(0, 16)) - 8.0) / 2.0);
      2: begin
        x = {$urandom, $urandom};
        if (x[62:52] == 11'h7FF) x[62] = 1'b0;
      end
      default: case ($urandom % 4)
        0: x = 64'h0000_0000_0000_0000;
        1: x = 64'h8000_0000_0000_0000;
        2: x = 64'h7FF0_0000_0000_0000;
        default: x = 64'hFFF0_0000_0000_0000;
      endcase
    endcase
    return x;
  endfunction

  function automatic logic [NW-1:0] mk_node(input int id, input logic [3:0] fidx, input logic [63:0] thr,
                                            input int left, input int right, input bit cls);
    logic [NW-1:0] w;
    w = '0;
    w[119:108] = 12'($urandom);
    w[3:1]     = 3'($urandom);
    w[107:96]  = 12'(id);
    w[95:92]   = fidx;
    w[91:28]   = thr;
    w[27:16]   = 12'(left);
    w[15:4]    = 12'(right);
    w[0]       = cls;
    return w;
  endfunction

  function automatic void model(output bit cls, output bit err, output int k);
    int addr, depth, child;
    logic [NW-1:0] w;
    addr = 0; depth = 0; k = 0; cls = 0; err = 0;
    forever begin
      k++;
      w = rom_mem[addr];
`ifdef TREE_WALKER_IDCHECK_EN
      if (int'(w[107:96]) != addr) begin err = 1; return; end
`endif
      if (w[95:92] == 4'h3) begin cls = w[0]; return; end
      child = fle(feat_v[int'(w[95:92]) % NF], w[91:28]) ? int'(w[27:16]) : int'(w[15:4]);
      if (child >= RD || depth + 1 > MD) begin err = 1; return; end
      addr = child;
      depth++;
    end
  endfunction

  task automatic rand_feats();
    for (int i = 0; i < NF; i++) feat_v[i] = rnd_dbl();
  endtask

  // Called #1 after an edge; the next edge accepts the walk.
  task automatic start_walk();
    for (int i = 0; i < NF; i++) features[64*i +: 64] = feat_v[i];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on_accept", busy, 1);
    check("addr_root", rom_addr, 0);
  endtask

  task automatic wait_done(input bit noise, input bit ecls, input bit eerr, input int ek);
    int n;
    n = 0;
    for (int c = 1; c <= 2*MD + 20; c++) begin
      @(posedge clk); #1;
      if (valid) begin n = c; break; end
      check("busy_walk", busy, 1);
      if (noise) begin
        start = 1'($urandom);
        for (int i = 0; i < NF; i++) features[64*i +: 64] = {$urandom, $urandom};
      end
    end
    start = 1'b0;
    if (n == 0) check("valid_timeout", 0, 1);
    else begin
      check("latency", n, 2*ek);
      check("class", class_out, ecls);
      check("error", error, eerr);
      check("busy_at_valid", busy, 0);
    end
  endtask

  task automatic run_walk(input bit noise);
    bit cls, err;
    int k;
    model(cls, err, k);
    start_walk();
    wait_done(noise, cls, err, k);
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    check("valid_pulse", valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_nodes, pulses;
    rst = 1'b1; start = 1'b0; features = '0;
    for (int a = 0; a < 1024; a++) rom_mem[a] = '0;
    for (int i = 0; i < NF; i++) feat_v[i] = '0;

    // comparator unit check, including signed zeros and equality
    fa = 64'h0; fb = 64'h8000_0000_0000_0000; #1; check("fp_le_p0_m0", fle_out, 0);
    fa = 64'h8000_0000_0000_0000; fb = 64'h0; #1; check("fp_le_m0_p0", fle_out, 1);
    fa = 64'hC000_0000_0000_0000; fb = 64'h4000_0000_0000_0000; #1; check("fp_le_neg", fle_out, 1);
    for (int i = 0; i < 200; i++) begin
      fa = rnd_dbl();
      fb = ($urandom % 4 == 0) ? fa : rnd_dbl();
      #1; check("fp_le_rand", fle_out, fle(fa, fb));
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_class", class_out, 0);
    check("rst_error", error, 0);
    check("rst_addr", rom_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // root is a leaf
    rom_mem[0] = mk_node(0, 4'h3, 64'h0, 0, 0, 1);
    rand_feats();
    run_walk(0);
    idle_check();

    // single split on feature 0 at 2.0
    rom_mem[0] = mk_node(0, 4'h0, 64'h4000_0000_0000_0000, 1, 2, 0);
    rom_mem[1] = mk_node(1, 4'h3, 64'h0, 0, 0, 0);
    rom_mem[2] = mk_node(2, 4'h3, 64'h0, 0, 0, 1);
    foreach (feat_v[i]) feat_v[i] = 64'h4000_0000_0000_0000;
    feat_v[0] = 64'h3FF0_0000_0000_0000; run_walk(0);
    feat_v[0] = 64'h4000_0000_0000_0000; run_walk(0);
    feat_v[0] = 64'h4008_0000_0000_0000; run_walk(0);
    feat_v[0] = 64'hC000_0000_0000_0000; run_walk(0);
    idle_check();

    // self loop hits the depth limit; out-of-range child aborts immediately
    rom_mem[0] = mk_node(0, 4'h1, 64'h0, 0, 0, 1);
    rand_feats(); run_walk(0);
    rom_mem[0] = mk_node(0, 4'h1, 64'h0, 12'h200, 12'h200, 1);
    run_walk(0);
    idle_check();

    // wrong node_id on word 1
    rom_mem[0] = mk_node(0, 4'h0, 64'h4000_0000_0000_0000, 1, 1, 0);
    rom_mem[1] = mk_node(5, 4'h3, 64'h0, 0, 0, 1);
    run_walk(0);
    idle_check();

    // reset during the second FETCH abandons the walk silently
    rom_mem[0] = mk_node(0, 4'h0, 64'h4000_0000_0000_0000, 1, 1, 0);
    rom_mem[1] = mk_node(1, 4'h2, 64'h0, 2, 2, 0);
    rom_mem[2] = mk_node(2, 4'h3, 64'h0, 0, 0, 1);
    rand_feats();
    start_walk();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", valid, 0);
    check("rst_mid_addr", rom_addr, 0);
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (valid) pulses++;
    end
    check("rst_no_pulse", pulses, 0);
    run_walk(0);

    // random trees, back-to-back walks, start/feature noise mid-walk
    for (int t = 0; t < 40; t++) begin
      n_nodes = $urandom_range(2, 12);
      for (int a = 0; a < n_nodes; a++) begin
        int id, l, r;
        id = ($urandom % 16 == 0) ? a + 1 : a;
        l = ($urandom % 12 == 0) ? $urandom_range(512, 4095) : $urandom_range(0, n_nodes - 1);
        r = ($urandom % 12 == 0) ? $urandom_range(512, 4095) : $urandom_range(0, n_nodes - 1);
        if ($urandom % 10 < 4) rom_mem[a] = mk_node(id, 4'h3, rnd_dbl(), l, r, 1'($urandom));
        else rom_mem[a] = mk_node(id, 4'($urandom), rnd_dbl(), l, r, 1'($urandom));
      end
      for (int j = 0; j < 4; j++) begin
        rand_feats();
        if ($urandom % 3 == 0) feat_v[$urandom % NF] = rom_mem[0][91:28];
        run_walk(1'($urandom));
        if ($urandom % 2 == 0) idle_check();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tree_walker.md
# tree_walker

Decision-tree traversal engine that acts as the read initiator for a synchronous tree node ROM. It accepts a latched feature vector on `start` and walks the tree from the root, issuing one ROM address at a time. At each internal node it compares one feature against the node threshold until it reaches a leaf, then returns a one-cycle `valid` pulse with the class bit. One instance sits in front of each per-tree ROM, and the ensemble voter consumes its class and valid outputs.

## Interface
- NODE_WIDTH, 120, ROM word width.
- ADDR_WIDTH, 10, ROM address width.
- ROM_DEPTH, 512, number of valid ROM words; addresses at or above this value are illegal.
- NUM_FEATURES, 16, number of 64-bit features in the vector.
- MAX_DEPTH, 32, maximum number of internal nodes visited before the walk aborts.
- clk  in  1  single clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin a walk; honoured only in IDLE.
- features  in  NUM_FEATURES*64  feature vector; feature i occupies bits [64*i+63 : 64*i]; sampled on the accepted-start edge.
- busy  out  1  high from the edge that accepts start until the edge that asserts valid.
- rom_addr  out  ADDR_WIDTH  registered address to the ROM.
- rom_data  in  NODE_WIDTH  ROM output, valid one cycle after rom_addr changes.
- valid  out  1  one-cycle pulse marking the end of a walk.
- class_out  out  1  leaf class; held until the next accepted start.
- error  out  1  qualified by valid; 1 means the walk aborted.

## Operation
- Node word fields:
  - [107:96] node_id.
  - [95:92] feature index; the value 4'h3 is reserved as the LEAF tag.
  - [91:28] threshold, 64-bit IEEE double.
  - [27:16] left child.
  - [15:4] right child.
  - [0] leaf class.
  - All other bits are ignored.
- States:
  - IDLE: on start, latch features, set rom_addr to 0 and the depth counter to 0, go to FETCH.
  - FETCH: one wait cycle while the ROM registers the word; go to EVAL.
  - EVAL, leaf word: capture the class, pulse valid with error=0, go to IDLE.
  - EVAL, internal word: pick child = (feature <= threshold) ? left : right, load rom_addr with the child, increment depth, go to FETCH.
- Compare rule: both operands are mapped to ordered unsigned keys.
  - If sign=0, key = value with the MSB set.
  - If sign=1, key = bitwise NOT of the value.
  - Keys are then compared as unsigned 64-bit numbers. +0 and -0 map to different keys; NaN ordering is undefined.
- The feature index is taken modulo NUM_FEATURES.
- Error abort: in EVAL, any of these conditions pulses valid with error=1 and class_out=0, then returns to IDLE:
  - the child address is >= ROM_DEPTH;
  - the depth counter would exceed MAX_DEPTH;
  - the ID check fails (see Configuration).
- start while busy is ignored, with no queuing.
- rst in any state forces IDLE on the next edge, abandoning the walk with no valid pulse.

## Timing
- Reset values: busy=0, valid=0, class_out=0, error=0, rom_addr=0, state IDLE.
- Each visited node costs 2 cycles (FETCH + EVAL).
- A walk visiting k nodes (internal nodes plus the leaf) asserts valid 2k cycles after the accepting edge.
  - Root is a leaf: valid is asserted 2 cycles after start.
- busy falls on the same edge that valid rises.
- A new start is accepted in the cycle valid is high.
  - Minimum issue interval: 2k+1 cycles.
- rom_addr changes only on the edge that enters FETCH.

## Configuration
- TREE_WALKER_IDCHECK_EN defined:
  - EVAL compares rom_data[107:96] against the current rom_addr, zero-extended to 12 bits.
  - A mismatch aborts the walk with error=1.
- Macro undefined:
  - node_id is ignored.
  - Only the bounds and depth errors remain.

## Structure
- Package tree_pkg holds:
  - node field offsets and widths;
  - LEAF_TAG (4'h3) and ROOT_ADDR (0);
  - the state enum;
  - the function that maps a double to its ordered key.
- Sub-module tree_fp_le: combinational 64-bit ordered less-than-or-equal using the package key function.
  - Instantiated once in tree_walker.
  - Unit-tested separately.

## Test plan
- ROM word 0 is a leaf with class 1; pulse start → valid at cycle +2, class_out=1, error=0, busy high for exactly 2 cycles.
- Root uses feature 0 with threshold 0x4000000000000000 (2.0), left leaf class 0, right leaf class 1:
  - feature0=0x3FF0000000000000 (1.0) → class 0 at +4;
  - 0x4000000000000000 → class 0 (equality goes left);
  - 0x4008000000000000 (3.0) → class 1;
  - 0xC000000000000000 (-2.0) → class 0.
- Internal node whose children both point to itself, MAX_DEPTH=4 → valid with error=1 at cycle +10; child address 0x200 → error=1 at +2.
- Assert rst during FETCH of level 2 → busy=0 on the next edge, no valid pulse; a subsequent start walks normally.
- start re-asserted every cycle during a walk → exactly one valid per accepted start; features changed mid-walk do not affect the result.
- With TREE_WALKER_IDCHECK_EN, word 1 carrying node_id 0x005 → error=1; without the macro, the same ROM completes with the leaf class.
